spu_wb_arbiter: RTL and testbench

Writeback-side producer for the SPU 128x128 register file. Collects results from the even and odd execution pipes, buffers each pipe in a small FIFO, and arbitrates them onto the register file's single write port (regwrite/wa/wd). Keeps a per-register busy scoreboard, set at issue and cleared at writeback, so the issue stage can detect RAW and WAW hazards.

---
 rtl/spu_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_spu_wb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_wb_arbiter.sv
// spu_wb_arbiter: writeback-side arbiter for the SPU register file.
// Buffers even/odd pipe results in per-pipe FIFOs, drains them onto the single
// register-file write port with round-robin on ties, and keeps a per-register
// busy scoreboard for issue-stage RAW/WAW hazard detection.
// Optional feature macro: WB_FWD_EN (adds forwarding-hit outputs and lets a
// forward hit mask the busy bit of the matching source operand).
module spu_wb_arbiter #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned REGBITS = 7,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [REGBITS-1:0] ev_rt,
  input  logic [WIDTH-1:0]   ev_wd,
  input  logic               od_valid,
  output logic               od_ready,
  input  logic [REGBITS-1:0] od_rt,
  input  logic [WIDTH-1:0]   od_wd,
  input  logic               iss_valid,
  input  logic [REGBITS-1:0] iss_rt,
  input  logic [REGBITS-1:0] q_ra1,
  input  logic [REGBITS-1:0] q_ra2,
  input  logic [REGBITS-1:0] q_rt,
  output logic               hazard,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               wb_err
`ifdef WB_FWD_EN
  ,
  output logic               fwd1_hit,
  output logic               fwd2_hit,
  output logic [WIDTH-1:0]   fwd_data
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned NREG = 1 << REGBITS;
  localparam logic [PW-1:0] PtrOne = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic {GntEven, GntOdd} grant_e;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [REGBITS-1:0] ev_rt_mem [DEPTH];
  logic [WIDTH-1:0]   ev_wd_mem [DEPTH];
  logic [REGBITS-1:0] od_rt_mem [DEPTH];
  logic [WIDTH-1:0]   od_wd_mem [DEPTH];
  logic [PW-1:0]      ev_wptr_q, ev_rptr_q, od_wptr_q, od_rptr_q;

  logic ev_full, ev_empty, od_full, od_empty;
  logic ev_push, od_push, ev_pop, od_pop, pop_valid;
  logic [REGBITS-1:0] pop_rt;
  logic [WIDTH-1:0]   pop_wd;

  grant_e            last_grant_q, last_grant_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wb_err_q, wb_err_d;
  logic              regwrite_q;
  logic [REGBITS-1:0] wa_q;
  logic [WIDTH-1:0]   wd_q;

  assign ev_full  = (ev_wptr_q[PW-1] != ev_rptr_q[PW-1]) &&
                    (ev_wptr_q[AW-1:0] == ev_rptr_q[AW-1:0]);
  assign od_full  = (od_wptr_q[PW-1] != od_rptr_q[PW-1]) &&
                    (od_wptr_q[AW-1:0] == od_rptr_q[AW-1:0]);
  assign ev_empty = (ev_wptr_q == ev_rptr_q);
  assign od_empty = (od_wptr_q == od_rptr_q);

  assign ev_ready = ~ev_full;
  assign od_ready = ~od_full;
  assign ev_push  = ev_valid & ~ev_full;
  assign od_push  = od_valid & ~od_full;

  // Entry storage: data needs no reset, emptiness is tracked by the pointers
  always_ff @(posedge clk) begin
    if (ev_push) begin
      ev_rt_mem[ev_wptr_q[AW-1:0]] <= ev_rt;
      ev_wd_mem[ev_wptr_q[AW-1:0]] <= ev_wd;
    end
    if (od_push) begin
      od_rt_mem[od_wptr_q[AW-1:0]] <= od_rt;
      od_wd_mem[od_wptr_q[AW-1:0]] <= od_wd;
    end
  end

  // FIFO pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_wptr_q <= '0;
      ev_rptr_q <= '0;
      od_wptr_q <= '0;
      od_rptr_q <= '0;
    end else begin
      if (ev_push) ev_wptr_q <= ev_wptr_q + PtrOne;
      if (ev_pop)  ev_rptr_q <= ev_rptr_q + PtrOne;
      if (od_push) od_wptr_q <= od_wptr_q + PtrOne;
      if (od_pop)  od_rptr_q <= od_rptr_q + PtrOne;
    end
  end

  // Arbitration on pre-push FIFO state; the grant pointer only moves on a tie
  always_comb begin
    ev_pop       = 1'b0;
    od_pop       = 1'b0;
    last_grant_d = last_grant_q;
    if (!ev_empty && !od_empty) begin
      if (last_grant_q == GntOdd) begin
        ev_pop       = 1'b1;
        last_grant_d = GntEven;
      end else begin
        od_pop       = 1'b1;
        last_grant_d = GntOdd;
      end
    end else if (!ev_empty) begin
      ev_pop = 1'b1;
    end else if (!od_empty) begin
      od_pop = 1'b1;
    end
  end

  assign pop_valid = ev_pop | od_pop;
  assign pop_rt    = ev_pop ? ev_rt_mem[ev_rptr_q[AW-1:0]] : od_rt_mem[od_rptr_q[AW-1:0]];
  assign pop_wd    = ev_pop ? ev_wd_mem[ev_rptr_q[AW-1:0]] : od_wd_mem[od_rptr_q[AW-1:0]];

  // Scoreboard update: clear on writeback first, so a same-edge issue set wins
  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    if (pop_valid) begin
      if (!busy_q[pop_rt]) wb_err_d = 1'b1;
      busy_d[pop_rt] = 1'b0;
    end
    if (iss_valid) busy_d[iss_rt] = 1'b1;
  end

  // Scoreboard, grant pointer and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      wb_err_q     <= 1'b0;
      last_grant_q <= GntOdd;
      regwrite_q   <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
    end else begin
      busy_q       <= busy_d;
      wb_err_q     <= wb_err_d;
      last_grant_q <= last_grant_d;
      regwrite_q   <= pop_valid;
      if (pop_valid) begin
        wa_q <= pop_rt;
        wd_q <= pop_wd;
      end
    end
  end

  assign regwrite = regwrite_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign wb_err   = wb_err_q;

`ifdef WB_FWD_EN
  assign fwd1_hit = regwrite_q && (wa_q == q_ra1);
  assign fwd2_hit = regwrite_q && (wa_q == q_ra2);
  assign fwd_data = wd_q;
  // A source being written this cycle can take the forwarded value instead
  assign hazard   = (busy_q[q_ra1] & ~fwd1_hit) | (busy_q[q_ra2] & ~fwd2_hit) | busy_q[q_rt];
`else
  assign hazard   = busy_q[q_ra1] | busy_q[q_ra2] | busy_q[q_rt];
`endif

endmodule

// File: tb/tb_spu_wb_arbiter.sv
// Self-checking bench for spu_wb_arbiter: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_spu_wb_arbiter;

  localparam int unsigned WIDTH   = 128;
  localparam int unsigned REGBITS = 7;
  localparam int unsigned DEPTH   = 4;

  logic               clk;
  logic               rst_n;
  logic               ev_valid, od_valid, iss_valid;
  logic               ev_ready, od_ready;
  logic [REGBITS-1:0] ev_rt, od_rt, iss_rt, q_ra1, q_ra2, q_rt;
  logic [WIDTH-1:0]   ev_wd, od_wd;
  logic               hazard, regwrite, wb_err;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
`ifdef WB_FWD_EN
  logic               fwd1_hit, fwd2_hit;
  logic [WIDTH-1:0]   fwd_data;
`endif

  spu_wb_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_rt     (ev_rt),
    .ev_wd     (ev_wd),
    .od_valid  (od_valid),
    .od_ready  (od_ready),
    .od_rt     (od_rt),
    .od_wd     (od_wd),
    .iss_valid (iss_valid),
    .iss_rt    (iss_rt),
    .q_ra1     (q_ra1),
    .q_ra2     (q_ra2),
    .q_rt      (q_rt),
    .hazard    (hazard),
    .regwrite  (regwrite),
    .wa        (wa),
    .wd        (wd),
    .wb_err    (wb_err)
`ifdef WB_FWD_EN
    ,
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [REGBITS-1:0] rt;
    logic [WIDTH-1:0]   wd;
  } ent_t;

  ent_t               evq[$];
  ent_t               odq[$];
  bit                 m_busy [1 << REGBITS];
  bit                 m_last_odd;
  bit                 m_regwrite;
  logic [REGBITS-1:0] m_wa;
  logic [WIDTH-1:0]   m_wd;
  bit                 m_err;
  bit                 m_ev_pushed, m_od_pushed;
  int                 wr_log[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    odq.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_odd  = 1'b1;
    m_regwrite  = 1'b0;
    m_wa        = '0;
    m_wd        = '0;
    m_err       = 1'b0;
    m_ev_pushed = 1'b0;
    m_od_pushed = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held before it
  task automatic model_edge();
    bit   ev_push, od_push, pop;
    ent_t e;
    ev_push = ev_valid && (evq.size() < DEPTH);
    od_push = od_valid && (odq.size() < DEPTH);
    pop = 1'b1;
    if (evq.size() > 0 && odq.size() > 0) begin
      if (m_last_odd) begin
        e = evq.pop_front();
        m_last_odd = 1'b0;
      end else begin
        e = odq.pop_front();
        m_last_odd = 1'b1;
      end
    end else if (evq.size() > 0) begin
      e = evq.pop_front();
    end else if (odq.size() > 0) begin
      e = odq.pop_front();
    end else begin
      pop = 1'b0;
    end
    m_regwrite = pop;
    if (pop) begin
      m_wa = e.rt;
      m_wd = e.wd;
      if (!m_busy[e.rt]) m_err = 1'b1;
      m_busy[e.rt] = 1'b0;
      wr_log.push_back(int'(e.rt));
    end
    if (iss_valid) m_busy[iss_rt] = 1'b1;
    if (ev_push) evq.push_back('{rt: ev_rt, wd: ev_wd});
    if (od_push) odq.push_back('{rt: od_rt, wd: od_wd});
    m_ev_pushed = ev_push;
    m_od_pushed = od_push;
  endtask

  function automatic bit model_hazard();
    bit h1, h2;
    h1 = m_busy[q_ra1];
    h2 = m_busy[q_ra2];
`ifdef WB_FWD_EN
    if (m_regwrite && m_wa == q_ra1) h1 = 1'b0;
    if (m_regwrite && m_wa == q_ra2) h2 = 1'b0;
`endif
    return h1 | h2 | m_busy[q_rt];
  endfunction

  task automatic check_all();
    check_eq("ev_ready", ev_ready, evq.size() < DEPTH);
    check_eq("od_ready", od_ready, odq.size() < DEPTH);
    check_eq("regwrite", regwrite, m_regwrite);
    check_eq("wa", wa, m_wa);
    check_eq("wd", wd, m_wd);
    check_eq("wb_err", wb_err, m_err);
    check_eq("hazard", hazard, model_hazard());
`ifdef WB_FWD_EN
    check_eq("fwd1_hit", fwd1_hit, m_regwrite && m_wa == q_ra1);
    check_eq("fwd2_hit", fwd2_hit, m_regwrite && m_wa == q_ra2);
    check_eq("fwd_data", fwd_data, m_wd);
`endif
  endtask

  // Inputs are driven at the falling edge; checks happen at the next one
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    ev_valid  = 1'b0;
    od_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  task automatic issue(input int rt);
    iss_valid = 1'b1;
    iss_rt    = REGBITS'(rt);
    step();
    iss_valid = 1'b0;
  endtask

  // Both pipes offer n results each back-to-back, holding each until accepted
  task automatic burst(input int ebase, input int obase, input int n,
                       output bit saw_ev_full, output bit saw_od_full);
    int ei, oi;
    ei = 0;
    oi = 0;
    saw_ev_full = 1'b0;
    saw_od_full = 1'b0;
    for (int i = 0; i < n; i++) issue(ebase + i);
    for (int i = 0; i < n; i++) issue(obase + i);
    wr_log.delete();
    for (int c = 0; c < 4 * n + 8; c++) begin
      ev_valid = (ei < n);
      od_valid = (oi < n);
      ev_rt    = REGBITS'(ebase + ei);
      od_rt    = REGBITS'(obase + oi);
      ev_wd    = {$urandom(), $urandom(), $urandom(), 32'(ebase + ei)};
      od_wd    = {$urandom(), $urandom(), $urandom(), 32'(obase + oi)};
      step();
      if (m_ev_pushed) ei++;
      if (m_od_pushed) oi++;
      if (!ev_ready) saw_ev_full = 1'b1;
      if (!od_ready) saw_od_full = 1'b1;
    end
    idle();
  endtask

  initial begin
    bit sf_e, sf_o;
    int exp_order[8];
    exp_order = '{1, 11, 2, 12, 3, 13, 4, 14};

    rst_n = 1'b0;
    idle();
    ev_rt = '0; od_rt = '0; iss_rt = '0;
    ev_wd = '0; od_wd = '0;
    q_ra1 = '0; q_ra2 = '0; q_rt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset/idle state, hazard low for a spread of queries
    for (int i = 0; i < 4; i++) begin
      q_ra1 = REGBITS'($urandom);
      q_ra2 = REGBITS'($urandom);
      q_rt  = REGBITS'($urandom);
      step();
    end
    check_eq("idle_regwrite", regwrite, 1'b0);

    // RAW: issue r5, result arrives, hazard until pop, write two cycles after push
    q_ra1 = 7'd5; q_ra2 = 7'd0; q_rt = 7'd0;
    issue(5);
    ev_valid = 1'b1; ev_rt = 7'd5; ev_wd = 128'hAA;
    step();
    check_eq("raw_hazard_pending", hazard, 1'b1);
    ev_valid = 1'b0;
    step();
    check_eq("raw_regwrite", regwrite, 1'b1);
    check_eq("raw_wa", wa, 7'd5);
    check_eq("raw_wd", wd, 128'hAA);
    check_eq("raw_hazard_cleared", hazard, 1'b0);
    step();
    check_eq("raw_regwrite_drop", regwrite, 1'b0);

    // Same-edge issue and writeback of r7: issue wins
    q_ra1 = 7'd0; q_rt = 7'd7;
    issue(7);
    ev_valid = 1'b1; ev_rt = 7'd7; ev_wd = 128'h77;
    step();
    ev_valid = 1'b0;
    iss_valid = 1'b1; iss_rt = 7'd7;
    step();
    iss_valid = 1'b0;
    check_eq("same_edge_wa", wa, 7'd7);
    check_eq("same_edge_hazard", hazard, 1'b1);
    check_eq("same_edge_no_err", wb_err, 1'b0);

    // Alternating drain order on a symmetric burst
    q_rt = 7'd0;
    burst(1, 11, 4, sf_e, sf_o);
    check_eq("burst4_count", 32'(wr_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) check_eq("burst4_order", 32'(wr_log[i]), 32'(exp_order[i]));

    // Longer burst fills both FIFOs; nothing lost
    burst(20, 40, 8, sf_e, sf_o);
    check_eq("burst8_count", 32'(wr_log.size()), 32'd16);
    check_eq("burst8_ev_full_seen", sf_e, 1'b1);
    check_eq("burst8_od_full_seen", sf_o, 1'b1);

    // Writeback to a non-busy register sets a sticky error
    ev_valid = 1'b1; ev_rt = 7'd9; ev_wd = 128'h99;
    step();
    ev_valid = 1'b0;
    step();
    check_eq("err_wa", wa, 7'd9);
    check_eq("err_set", wb_err, 1'b1);
    repeat (3) step();
    check_eq("err_sticky", wb_err, 1'b1);

    // Randomized traffic; producers hold their result until accepted
    for (int c = 0; c < 1500; c++) begin
      if (!ev_valid || m_ev_pushed) begin
        ev_valid = ($urandom_range(0, 9) < 7);
        ev_rt    = REGBITS'($urandom_range(0, 15));
        ev_wd    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!od_valid || m_od_pushed) begin
        od_valid = ($urandom_range(0, 9) < 6);
        od_rt    = REGBITS'($urandom_range(0, 15));
        od_wd    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rt    = REGBITS'($urandom_range(0, 15));
      q_ra1     = REGBITS'($urandom_range(0, 15));
      q_ra2     = REGBITS'($urandom_range(0, 15));
      q_rt      = REGBITS'($urandom_range(0, 15));
      step();
    end

    // Asynchronous reset mid-traffic clears everything without a clock edge
    ev_valid = 1'b1; od_valid = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_regwrite", regwrite, 1'b0);
    check_eq("arst_ev_ready", ev_ready, 1'b1);
    check_eq("arst_od_ready", od_ready, 1'b1);
    check_eq("arst_wb_err", wb_err, 1'b0);
    check_eq("arst_wa", wa, 7'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    repeat (3) step();
    check_eq("post_rst_regwrite", regwrite, 1'b0);

    // Short burst after reset to confirm normal operation resumes
    burst(60, 70, 3, sf_e, sf_o);
    check_eq("post_rst_count", 32'(wr_log.size()), 32'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
